// File: rtl/dc_wb_buffer.sv
// -----------------------------------------------------------------------------
// dc_wb_buffer
//   Dirty-victim write-back buffer for the dcache. On a miss it picks the victim
//   way from the LRU bit. A valid, dirty victim line is queued with its address
//   and owning thread in a small FIFO. Queued lines are drained to L2 over a
//   req/ack handshake, so miss refills never wait on L2 writes.
//
// Optional feature (compile-time macro DC_WB_FWD_EN):
//   defined   - fwd_addr is compared against every queued entry; fwd_hit and
//               fwd_data return the youngest matching entry.
//   undefined - fwd_hit and fwd_data are tied to 0; no compare logic is built.
//
// Ports
//   clk, reset             clock; asynchronous active-low reset
//   wb_push, wb_index      miss needs eviction this cycle; set index of the miss
//   lru                    1 -> victim is way1, 0 -> victim is way0
//   tag0_rd/tag1_rd        way tags, valid bit in the MSB
//   dirty0/1, thread0/1    way dirty bits and owning threads
//   line0_rd/line1_rd      way data lines
//   l2_wr_ack              one-cycle L2 accept pulse
//   l2_wr_req/addr/data/thread  write-back request and head entry to L2
//   wb_full, wb_busy       FIFO full (registered); FIFO or FSM active
//   wb_ovf                 sticky: a qualifying push was dropped while full
//   fwd_addr/fwd_hit/fwd_data  refill-path lookup into the queued lines
// -----------------------------------------------------------------------------
module dc_wb_buffer #(
    parameter int DEPTH  = 4,
    parameter int LINE_W = 128,
    parameter int TAG_W  = 21,
    parameter int IDX_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_push,
    input  logic [IDX_W-1:0]         wb_index,
    input  logic                     lru,
    input  logic [TAG_W-1:0]         tag0_rd,
    input  logic [TAG_W-1:0]         tag1_rd,
    input  logic                     dirty0,
    input  logic                     dirty1,
    input  logic [1:0]               thread0,
    input  logic [1:0]               thread1,
    input  logic [LINE_W-1:0]        line0_rd,
    input  logic [LINE_W-1:0]        line1_rd,
    input  logic                     l2_wr_ack,
    output logic                     l2_wr_req,
    output logic [TAG_W+IDX_W-2:0]   l2_wr_addr,
    output logic [LINE_W-1:0]        l2_wr_data,
    output logic [1:0]               l2_wr_thread,
    output logic                     wb_full,
    output logic                     wb_busy,
    output logic                     wb_ovf,
    input  logic [TAG_W+IDX_W-2:0]   fwd_addr,
    output logic                     fwd_hit,
    output logic [LINE_W-1:0]        fwd_data
);

    localparam int ADDR_W = TAG_W - 1 + IDX_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q;
    logic              ovf_q, ovf_d;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [LINE_W-1:0] data_mem [DEPTH];
    logic [1:0]        thr_mem  [DEPTH];

    // Victim selection straight from the LRU bit.
    logic [TAG_W-1:0]  vic_tag;
    logic              vic_dirty;
    logic [1:0]        vic_thread;
    logic [LINE_W-1:0] vic_line;
    logic [ADDR_W-1:0] vic_addr;

    assign vic_tag    = lru ? tag1_rd  : tag0_rd;
    assign vic_dirty  = lru ? dirty1   : dirty0;
    assign vic_thread = lru ? thread1  : thread0;
    assign vic_line   = lru ? line1_rd : line0_rd;
    assign vic_addr   = {vic_tag[TAG_W-2:0], wb_index};

    logic push_qual, push_acc, pop;

    assign pop       = (state_q == S_REQ) && l2_wr_ack;
    assign push_qual = wb_push && vic_tag[TAG_W-1] && vic_dirty;
    // A full FIFO can still take the push when the head leaves on the same edge;
    // the freed slot is exactly the one the write pointer points at.
    assign push_acc  = push_qual && (!full_q || pop);

    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (pop)      rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (push_qual && !push_acc) ovf_d = 1'b1;
        case ({push_acc, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (count_q != '0) state_d = S_REQ;
            S_REQ:   if (l2_wr_ack) state_d = S_GAP;
            // One forced low cycle between transfers.
            S_GAP:   state_d = (count_q != '0) ? S_REQ : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == FULL_CNT);
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: the entry storage has no reset; which slots hold live data is
    // decided solely by the pointers and count, which are reset.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            addr_mem[wr_ptr_q] <= vic_addr;
            data_mem[wr_ptr_q] <= vic_line;
            thr_mem[wr_ptr_q]  <= vic_thread;
        end
    end

    // Head entry is only presented while requesting, so the bus reads 0 otherwise.
    assign l2_wr_req    = (state_q == S_REQ);
    assign l2_wr_addr   = l2_wr_req ? addr_mem[rd_ptr_q] : '0;
    assign l2_wr_data   = l2_wr_req ? data_mem[rd_ptr_q] : '0;
    assign l2_wr_thread = l2_wr_req ? thr_mem[rd_ptr_q]  : '0;
    assign wb_full      = full_q;
    assign wb_busy      = (count_q != '0) || (state_q != S_IDLE);
    assign wb_ovf       = ovf_q;

`ifdef DC_WB_FWD_EN
    logic [PTR_W-1:0] fwd_slot;

    // Walk oldest to youngest; a later match overrides an earlier one so the
    // youngest copy of a line wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_slot = rd_ptr_q;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_slot = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (addr_mem[fwd_slot] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[fwd_slot];
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^fwd_addr;
    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
`endif

endmodule
